// File: rtl/rs_encoder_256.sv
// Systematic RS(255-NSYM+..) encoder over GF(2^8), poly 0x11D; message passthrough then NSYM parity symbols.
// Latency: one cycle from an accepted input symbol to out_data; parity follows the last message symbol immediately.
// Backpressure: with RS_ENC_BACKPRESSURE_EN a stalled out_ready holds the output stage and freezes the LFSR; without it out_ready is ignored.
module rs_encoder_256 #(
    parameter int NSYM = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] msg_len,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic       len_err
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    // GF(2^8) multiply: shift-and-reduce by 0x11D
    function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    // g(x) = prod (x + alpha^r), r = 0..NSYM-1; monic term g[NSYM] is implicit
    function automatic logic [NSYM-1:0][7:0] gen_poly();
        logic [NSYM:0][7:0] g;
        logic [7:0]         root;
        g    = '0;
        g[0] = 8'h01;
        root = 8'h01;
        for (int r = 0; r < NSYM; r++) begin
            for (int j = NSYM; j >= 1; j--) begin
                g[j] = g[j-1] ^ gfmul(g[j], root);
            end
            g[0] = gfmul(g[0], root);
            root = gfmul(root, 8'h02);
        end
        return g[NSYM-1:0];
    endfunction

    localparam logic [NSYM-1:0][7:0] G       = gen_poly();
    localparam logic [31:0]          MAX_LEN = 32'(255 - NSYM);

    state_t               state;
    logic [7:0]           cnt;
    logic [NSYM-1:0][7:0] par;
    logic [NSYM-1:0][7:0] par_in;
    logic [NSYM-1:0][7:0] par_sh;
    logic [7:0]           fb;
    logic                 ready_eff;
    logic                 slot_free;
    logic                 in_fire;
    logic                 len_ok;

`ifdef RS_ENC_BACKPRESSURE_EN
    assign ready_eff = out_ready;
`else
    // every presented symbol is a transfer; out_ready has no effect
    logic unused_out_ready;
    assign unused_out_ready = out_ready;
    assign ready_eff        = 1'b1;
`endif

    assign slot_free = !out_valid || ready_eff;
    assign in_ready  = (state == DATA) && slot_free;
    assign in_fire   = in_valid && in_ready;
    assign fb        = in_data ^ par[NSYM-1];
    assign len_ok    = (msg_len != 8'd0) && ({24'd0, msg_len} <= MAX_LEN);

    // next LFSR contents for a message symbol, and the plain shift used while emitting parity
    always_comb begin
        par_in    = '0;
        par_sh    = '0;
        par_in[0] = gfmul(fb, G[0]);
        for (int i = 1; i < NSYM; i++) begin
            par_in[i] = par[i-1] ^ gfmul(fb, G[i]);
            par_sh[i] = par[i-1];
        end
    end

    // control FSM, LFSR and registered output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            par       <= '0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            len_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            state <= DATA;
                            cnt   <= msg_len;
                            par   <= '0;
                            busy  <= 1'b1;
                        end else begin
                            len_err <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (slot_free) begin
                        out_valid <= in_fire;
                        out_last  <= 1'b0;
                    end
                    if (in_fire) begin
                        out_data <= in_data;
                        par      <= par_in;
                        if (cnt == 8'd1) begin
                            state <= PARITY;
                            cnt   <= 8'(NSYM);
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                end
                PARITY: begin
                    if (slot_free) begin
                        if (cnt != 8'd0) begin
                            out_data  <= par[NSYM-1];
                            out_valid <= 1'b1;
                            out_last  <= (cnt == 8'd1);
                            par       <= par_sh;
                            cnt       <= cnt - 8'd1;
                        end else begin
                            // final parity symbol has just been taken
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_encoder_256.sv
// Directed bench: NSYM=2 instance for hand-computed codewords, NSYM=16 instance for full-length codewords.
// Codewords of the wide instance are checked by evaluating them at alpha^0..alpha^15.
// Output transfers are collected at the falling edge into per-instance queues.
module tb_rs_encoder_256;

`ifdef RS_ENC_BACKPRESSURE_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      start;
    logic [1:0][7:0] msg_len;
    logic [1:0][7:0] in_data;
    logic [1:0]      in_valid;
    logic [1:0]      in_ready;
    logic [1:0][7:0] out_data;
    logic [1:0]      out_valid;
    logic [1:0]      out_ready;
    logic [1:0]      out_last;
    logic [1:0]      busy;
    logic [1:0]      len_err;
    logic [1:0]      rnd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] dat;
        logic       last;
        int         cyc;
    } beat_t;

    typedef struct {
        int              len;
        logic [0:3][7:0] m;
        logic [0:5][7:0] e;
    } vec_t;

    beat_t      q0[$];
    beat_t      q1[$];
    logic [7:0] msg [256];
    vec_t       tv [6];
    logic       st0 = 1'b0;
    logic [8:0] held0;

    always #5 clk = ~clk;

    rs_encoder_256 #(.NSYM(2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .msg_len(msg_len[0]),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_last(out_last[0]), .busy(busy[0]), .len_err(len_err[0])
    );

    rs_encoder_256 #(.NSYM(16)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .msg_len(msg_len[1]),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_last(out_last[1]), .busy(busy[1]), .len_err(len_err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // independent GF multiply: carry-less product, then polynomial reduction
    function automatic logic [7:0] gfm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11D << (i - 8));
        return p[7:0];
    endfunction

    // codeword collected from the wide instance evaluated at alpha^r
    function automatic logic [7:0] syn1(input int r);
        logic [7:0] a;
        logic [7:0] s;
        a = 8'h01;
        for (int i = 0; i < r; i++) a = gfm(a, 8'h02);
        s = 8'h00;
        foreach (q1[k]) s = gfm(s, a) ^ q1[k].dat;
        return s;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) out_ready[i] = rnd[i] ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (out_valid[0] && (out_ready[0] || !BP)) q0.push_back('{out_data[0], out_last[0], cyc});
        if (out_valid[1] && (out_ready[1] || !BP)) q1.push_back('{out_data[1], out_last[1], cyc});
        if (st0 && rst_n) check("stall_hold", {23'd0, out_last[0], out_data[0]}, {23'd0, held0});
        st0   = out_valid[0] && !out_ready[0] && BP;
        held0 = {out_last[0], out_data[0]};
    end

    task automatic send(input int s, input int len);
        int k;
        int guard;
        bit acc;
        @(negedge clk);
        start[s]   = 1'b1;
        msg_len[s] = 8'(len);
        @(negedge clk);
        start[s] = 1'b0;
        k = 0;
        guard = 0;
        while (k < len && guard < 5000) begin
            in_valid[s] = 1'b1;
            in_data[s]  = msg[k];
            acc         = in_ready[s];
            @(negedge clk);
            if (acc) k++;
            guard++;
        end
        in_valid[s] = 1'b0;
        if (guard >= 5000) check("send_timeout", 32'(k), 32'(len));
    endtask

    task automatic wait_idle(input int s);
        int guard;
        guard = 0;
        while ((busy[s] || out_valid[s]) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) check("idle_timeout", 32'(busy[s]), 32'd0);
    endtask

    task automatic bad_len(input int s, input int len, input string name);
        @(negedge clk);
        start[s]   = 1'b1;
        msg_len[s] = 8'(len);
        @(negedge clk);
        start[s] = 1'b0;
        check({name, "_len_err"}, 32'(len_err[s]), 32'd1);
        check({name, "_busy"}, 32'(busy[s]), 32'd0);
        @(negedge clk);
        check({name, "_len_err_pulse"}, 32'(len_err[s]), 32'd0);
    endtask

    task automatic run_vec(input int v, input string name);
        int n;
        for (int k = 0; k < tv[v].len; k++) msg[k] = tv[v].m[k];
        n = tv[v].len + 2;
        q0.delete();
        send(0, tv[v].len);
        wait_idle(0);
        check({name, "_count"}, 32'(q0.size()), 32'(n));
        for (int j = 0; j < n; j++) begin
            check({name, "_data"}, (j < q0.size()) ? 32'(q0[j].dat) : 32'hDEAD, 32'(tv[v].e[j]));
            check({name, "_last"}, (j < q0.size()) ? 32'(q0[j].last) : 32'hDEAD, 32'(j == n - 1));
        end
        check({name, "_busy_after"}, 32'(busy[0]), 32'd0);
    endtask

    initial begin
        int zeros;
        int lasts;
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
        zeros = 0;
        lasts = 0;
    end

    initial begin
        int nz;
        int nl;
        int mm;
        start    = '0;
        msg_len  = '0;
        in_data  = '0;
        in_valid = '0;
        rnd      = '0;
        out_ready = '1;

        tv[0] = '{1, {8'h01, 8'h00, 8'h00, 8'h00}, {8'h01, 8'h03, 8'h02, 8'h00, 8'h00, 8'h00}};
        tv[1] = '{1, {8'h02, 8'h00, 8'h00, 8'h00}, {8'h02, 8'h06, 8'h04, 8'h00, 8'h00, 8'h00}};
        tv[2] = '{2, {8'h01, 8'h00, 8'h00, 8'h00}, {8'h01, 8'h00, 8'h07, 8'h06, 8'h00, 8'h00}};
        tv[3] = '{3, {8'h01, 8'h02, 8'h03, 8'h00}, {8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h00}};
        tv[4] = '{1, {8'h80, 8'h00, 8'h00, 8'h00}, {8'h80, 8'h9D, 8'h1D, 8'h00, 8'h00, 8'h00}};
        tv[5] = '{4, {8'h00, 8'h00, 8'h00, 8'h01}, {8'h00, 8'h00, 8'h00, 8'h01, 8'h03, 8'h02}};

        // reset state
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_out_valid", 32'(out_valid[s]), 32'd0);
            check("rst_out_data", 32'(out_data[s]), 32'd0);
            check("rst_out_last", 32'(out_last[s]), 32'd0);
            check("rst_busy", 32'(busy[s]), 32'd0);
            check("rst_len_err", 32'(len_err[s]), 32'd0);
            check("rst_in_ready", 32'(in_ready[s]), 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // hand-computed NSYM=2 codewords, gapless in and out
        for (int v = 0; v < 6; v++) begin
            run_vec(v, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_gapless", v),
                  (q0.size() == tv[v].len + 2) ? 32'(q0[q0.size()-1].cyc - q0[0].cyc) : 32'hDEAD,
                  32'(tv[v].len + 1));
        end

        // random output backpressure on the T1 stimulus
        rnd[0] = 1'b1;
        run_vec(0, "bp_t1");
        run_vec(3, "bp_vec3");
        rnd[0] = 1'b0;

        // all-zero maximum-length message, NSYM=16
        for (int k = 0; k < 239; k++) msg[k] = 8'h00;
        q1.delete();
        send(1, 239);
        wait_idle(1);
        nz = 0;
        nl = 0;
        foreach (q1[k]) begin
            if (q1[k].dat != 8'h00) nz++;
            if (q1[k].last) nl++;
        end
        check("zero_count", 32'(q1.size()), 32'd255);
        check("zero_nonzero_syms", 32'(nz), 32'd0);
        check("zero_last_count", 32'(nl), 32'd1);
        check("zero_last_pos", (q1.size() == 255) ? 32'(q1[254].last) : 32'hDEAD, 32'd1);
        check("zero_gapless", (q1.size() == 255) ? 32'(q1[254].cyc - q1[0].cyc) : 32'hDEAD, 32'd254);
        check("zero_busy_after", 32'(busy[1]), 32'd0);

        // random 223-symbol message: passthrough and zero syndromes
        for (int k = 0; k < 223; k++) msg[k] = 8'($urandom_range(0, 255));
        q1.delete();
        send(1, 223);
        wait_idle(1);
        mm = 0;
        for (int k = 0; k < 223 && k < q1.size(); k++) if (q1[k].dat != msg[k]) mm++;
        check("rand_count", 32'(q1.size()), 32'd239);
        check("rand_passthrough", 32'(mm), 32'd0);
        for (int r = 0; r < 16; r++) check($sformatf("rand_syn%0d", r), 32'(syn1(r)), 32'd0);

        // illegal lengths
        bad_len(1, 0, "len0_n16");
        bad_len(1, 240, "len240_n16");
        bad_len(0, 254, "len254_n2");
        bad_len(0, 0, "len0_n2");

        // start while busy is ignored, even with an illegal length
        q0.delete();
        @(negedge clk);
        start[0]   = 1'b1;
        msg_len[0] = 8'd3;
        @(negedge clk);
        start[0]    = 1'b1;
        msg_len[0]  = 8'd0;
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h01;
        @(negedge clk);
        check("busy_start_len_err", 32'(len_err[0]), 32'd0);
        start[0]   = 1'b0;
        in_data[0] = 8'h02;
        @(negedge clk);
        in_data[0] = 8'h03;
        @(negedge clk);
        in_valid[0] = 1'b0;
        wait_idle(0);
        check("busy_start_count", 32'(q0.size()), 32'd5);
        for (int j = 0; j < 5; j++)
            check("busy_start_data", (j < q0.size()) ? 32'(q0[j].dat) : 32'hDEAD, 32'(tv[3].e[j]));

        // reset during the fifth parity beat
        msg[0] = 8'h11; msg[1] = 8'h22; msg[2] = 8'h33; msg[3] = 8'h44;
        q1.delete();
        send(1, 4);
        begin
            int guard;
            guard = 0;
            while (q1.size() < 8 && guard < 100) begin
                @(posedge clk);
                #2;
                guard++;
            end
            check("abort_reach_beat5", 32'(q1.size() >= 8), 32'd1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid[1]), 32'd0);
        check("abort_out_data", 32'(out_data[1]), 32'd0);
        check("abort_out_last", 32'(out_last[1]), 32'd0);
        check("abort_busy", 32'(busy[1]), 32'd0);
        check("abort_in_ready", 32'(in_ready[1]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) msg[k] = 8'($urandom_range(0, 255));
        q1.delete();
        send(1, 5);
        wait_idle(1);
        check("after_abort_count", 32'(q1.size()), 32'd21);
        for (int r = 0; r < 16; r++) check($sformatf("after_abort_syn%0d", r), 32'(syn1(r)), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
